// File: rtl/modlins_sched.sv
// modlins_sched: issue scheduler for the shared modular linear unit (modlins).
// Arbitrates NREQ requesters round-robin onto the unit's single issue port,
// registers the issue inputs, follows each operation through a LAT-deep tag
// pipeline and returns the result tagged with requester id and destination rn.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (ready is one-hot or 0)
//   req_op/req_a/req_b/req_rn   packed per-requester op, operands, dest tag
//   hold                        suppresses new grants
//   idle                        nothing issued or in flight
//   lins_en/op/a/b/rn           registered issue port to the unit
//   lins_res_i, lins_rn_i       unit result and echoed tag
//   rsp_valid/id/rn/res         tagged response stream (no backpressure)
//   tag_err                     sticky returned-tag mismatch flag
module modlins_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LAT      = 4,
  parameter int unsigned WORDSZ   = 32,
  parameter int unsigned RFSZLOG2 = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [2*NREQ-1:0]          req_op,
  input  logic [WORDSZ*NREQ-1:0]     req_a,
  input  logic [WORDSZ*NREQ-1:0]     req_b,
  input  logic [RFSZLOG2*NREQ-1:0]   req_rn,
  input  logic                       hold,
  output logic                       idle,
  output logic                       lins_en,
  output logic [1:0]                 lins_op,
  output logic [WORDSZ-1:0]          lins_a,
  output logic [WORDSZ-1:0]          lins_b,
  output logic [RFSZLOG2-1:0]        lins_rn,
  input  logic [WORDSZ-1:0]          lins_res_i,
  input  logic [RFSZLOG2-1:0]        lins_rn_i,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [RFSZLOG2-1:0]        rsp_rn,
  output logic [WORDSZ-1:0]          rsp_res,
  output logic                       tag_err
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_found;
  logic                hs;
  logic [31:0]         cand_w;
  logic [IDW-1:0]      cand;

  logic [1:0]          sel_op;
  logic [WORDSZ-1:0]   sel_a;
  logic [WORDSZ-1:0]   sel_b;
  logic [RFSZLOG2-1:0] sel_rn;

  logic [IDW-1:0]      iss_id;
  logic [LAT-1:0]      tv;
  logic [IDW-1:0]      tid [LAT];
  logic [RFSZLOG2-1:0] trn [LAT];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_w    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_w = (32'(ptr) + k) % NREQ;
      cand   = IDW'(cand_w);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign hs = gnt_found & ~hold;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_rn = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WORDSZ*i +: WORDSZ];
        sel_b  = req_b[WORDSZ*i +: WORDSZ];
        sel_rn = req_rn[RFSZLOG2*i +: RFSZLOG2];
      end
    end
  end

  // Pointer and issue register; issue fields are zeroed when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= IDW'(NREQ - 1);
      lins_en <= 1'b0;
      lins_op <= '0;
      lins_a  <= '0;
      lins_b  <= '0;
      lins_rn <= '0;
      iss_id  <= '0;
    end else begin
      lins_en <= hs;
      if (hs) begin
        ptr     <= gnt_idx;
        lins_op <= sel_op;
        lins_a  <= sel_a;
        lins_b  <= sel_b;
        lins_rn <= sel_rn;
        iss_id  <= gnt_idx;
      end else begin
        lins_op <= '0;
        lins_a  <= '0;
        lins_b  <= '0;
        lins_rn <= '0;
        iss_id  <= '0;
      end
    end
  end

  // Tag pipeline shifts every cycle; the unit cannot stall, so it stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tid[i] <= '0;
        trn[i] <= '0;
      end
    end else begin
      tv[0]  <= lins_en;
      tid[0] <= iss_id;
      trn[0] <= lins_rn;
      for (int unsigned i = 1; i < LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
        trn[i] <= trn[i-1];
      end
    end
  end

  assign rsp_valid = tv[LAT-1];
  assign rsp_id    = tid[LAT-1];
  assign rsp_rn    = trn[LAT-1];
  assign rsp_res   = rsp_valid ? lins_res_i : '0;
  assign idle      = ~lins_en & ~(|tv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (rsp_valid && (lins_rn_i != rsp_rn)) begin
      tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_modlins_sched.sv
// Directed self-checking bench for modlins_sched with a behavioural
// 4-cycle modular unit (P = 65521) attached to the issue port.
module tb_modlins_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int WS   = 16;
  localparam int RB   = 4;
  localparam logic [WS:0]   PW = 17'h0FFF1;
  localparam logic [WS-1:0] P  = 16'hFFF1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_op;
  logic [WS*NREQ-1:0]   req_a;
  logic [WS*NREQ-1:0]   req_b;
  logic [RB*NREQ-1:0]   req_rn;
  logic                 hold;
  logic                 idle;
  logic                 lins_en;
  logic [1:0]           lins_op;
  logic [WS-1:0]        lins_a;
  logic [WS-1:0]        lins_b;
  logic [RB-1:0]        lins_rn;
  logic [WS-1:0]        lins_res_i;
  logic [RB-1:0]        lins_rn_i;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [RB-1:0]        rsp_rn;
  logic [WS-1:0]        rsp_res;
  logic                 tag_err;
  logic [RB-1:0]        rn_flip;

  int errors = 0;
  int checks = 0;

  modlins_sched #(.NREQ(NREQ), .LAT(LAT), .WORDSZ(WS), .RFSZLOG2(RB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rn(req_rn), .hold(hold),
    .idle(idle), .lins_en(lins_en), .lins_op(lins_op), .lins_a(lins_a),
    .lins_b(lins_b), .lins_rn(lins_rn), .lins_res_i(lins_res_i),
    .lins_rn_i(lins_rn_i), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rn(rsp_rn), .rsp_res(rsp_res), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  // Behavioural modlins: result appears LAT cycles after lins_en; not reset.
  function automatic logic [WS-1:0] calc(input logic [1:0] op, input logic [WS-1:0] a,
                                         input logic [WS-1:0] b);
    logic [WS:0] s;
    case (op)
      2'd0:    s = (a == '0) ? '0 : PW - {1'b0, a};
      2'd1:    s = {1'b0, a} + {1'b0, a};
      2'd2:    s = {1'b0, a} + {1'b0, b};
      default: s = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + PW - {1'b0, b};
    endcase
    if (s >= PW) s = s - PW;
    return s[WS-1:0];
  endfunction

  logic [WS-1:0] u_res [LAT];
  logic [RB-1:0] u_rn  [LAT];
  initial for (int i = 0; i < LAT; i++) begin u_res[i] = '0; u_rn[i] = '0; end
  always @(posedge clk) begin
    u_res[0] <= calc(lins_op, lins_a, lins_b);
    u_rn[0]  <= lins_rn;
    for (int i = 1; i < LAT; i++) begin
      u_res[i] <= u_res[i-1];
      u_rn[i]  <= u_rn[i-1];
    end
  end
  assign lins_res_i = u_res[LAT-1];
  assign lins_rn_i  = u_rn[LAT-1] ^ rn_flip;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b, input int rn);
    req_op[2*i +: 2]  = 2'(op);
    req_a[WS*i +: WS] = WS'(a);
    req_b[WS*i +: WS] = WS'(b);
    req_rn[RB*i +: RB] = RB'(rn);
  endtask

  task automatic drain;
    repeat (LAT + 3) step();
  endtask

  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) set_req(i, 2, i + 1, 1, i);
    req_valid = 4'hF;
    step(); step(); step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready got=%h exp=0", req_ready); end
    checks++; if ({lins_en, lins_op, lins_a, lins_b, lins_rn} !== '0) begin errors++; $display("FAIL rst_lins got en=%b a=%h b=%h exp=0", lins_en, lins_a, lins_b); end
    checks++; if ({rsp_valid, rsp_id, rsp_rn, rsp_res} !== '0) begin errors++; $display("FAIL rst_rsp got v=%b id=%0d rn=%0d res=%h exp=0", rsp_valid, rsp_id, rsp_rn, rsp_res); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL rst_tag_err got=%b exp=0", tag_err); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL post_rst_quiet cyc=%0d got v=%b idle=%b exp v=0 idle=1", c, rsp_valid, idle); end
      step();
    end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_single_add;
    set_req(1, 2, 5, 7, 3);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL add_ready got=%b exp=0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if ({lins_en, lins_op, lins_a, lins_b, lins_rn} !== {1'b1, 2'd2, 16'd5, 16'd7, 4'd3}) begin
      errors++; $display("FAIL add_issue got en=%b op=%0d a=%0d b=%0d rn=%0d exp 1/2/5/7/3", lins_en, lins_op, lins_a, lins_b, lins_rn); end
    step(); #1;
    checks++; if (lins_en !== 1'b0 || lins_a !== '0) begin errors++; $display("FAIL add_issue_clear got en=%b a=%0d exp 0/0", lins_en, lins_a); end
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early got=%b exp=0", rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_rn, rsp_res} !== {1'b1, 2'd1, 4'd3, 16'd12}) begin
      errors++; $display("FAIL add_rsp got v=%b id=%0d rn=%0d res=%0d exp 1/1/3/12", rsp_valid, rsp_id, rsp_rn, rsp_res); end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_res !== '0) begin errors++; $display("FAIL add_rsp_end got v=%b res=%0d exp 0/0", rsp_valid, rsp_res); end
    drain();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 2, i, i, i);
    req_valid = 4'hF;
    step();
    rst_n = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 6) req_valid = '0;
      #1;
      exp_rdy = (c < 6) ? 4'(1 << (c % 4)) : 4'h0;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (c >= 5) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 5) % 4) || rsp_res !== 16'(2 * ((c - 5) % 4))) begin
          errors++; $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d res=%0d exp 1/%0d/%0d", c, rsp_valid, rsp_id, rsp_res, (c - 5) % 4, 2 * ((c - 5) % 4)); end
      end
      step();
    end
    drain();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
    set_req(2, 3, 1, 2, 6);
    req_valid = 4'b0100;
    for (int c = 0; c <= 13; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      checks++; if (req_ready !== ((c < 8) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL b2b_grant cyc=%0d got=%b", c, req_ready); end
      if (c >= 5 && c <= 12) begin
        checks++; if ({rsp_valid, rsp_id, rsp_rn, rsp_res} !== {1'b1, 2'd2, 4'd6, P - 16'd1}) begin
          errors++; $display("FAIL b2b_rsp cyc=%0d got v=%b id=%0d rn=%0d res=%0d exp 1/2/6/%0d", c, rsp_valid, rsp_id, rsp_rn, rsp_res, P - 16'd1); end
      end
      if (c == 13) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", rsp_valid); end
      end
      step();
    end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_ptr got=%b exp=1000", req_ready); end
    req_valid = '0;
    drain();
  endtask

  task automatic test_hold;
    logic [3:0] exp_rdy;
    // ptr is 2 on entry (the b2b pointer probe made no handshake).
    for (int i = 0; i < NREQ; i++) set_req(i, 0, i + 1, 0, i);
    req_valid = 4'hF;
    for (int c = 0; c <= 16; c++) begin
      if (c == 3) begin hold = 1'b1; req_valid = 4'b0110; end
      if (c == 10) begin hold = 1'b0; req_valid = 4'hF; end
      if (c == 12) req_valid = '0;
      #1;
      case (c)
        0: exp_rdy = 4'b1000;
        1: exp_rdy = 4'b0001;
        2: exp_rdy = 4'b0010;
        10: exp_rdy = 4'b0100;
        11: exp_rdy = 4'b1000;
        default: exp_rdy = 4'b0000;
      endcase
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL hold_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (c == 4) begin
        checks++; if (lins_en !== 1'b0) begin errors++; $display("FAIL hold_no_issue got=%b exp=0", lins_en); end
      end
      if (c >= 5 && c <= 7) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_res !== P - 16'(((c - 2) % 4) + 1)) begin
          errors++; $display("FAIL hold_rsp cyc=%0d got v=%b id=%0d res=%0d exp id=%0d", c, rsp_valid, rsp_id, rsp_res, (c - 2) % 4); end
      end
      if (c >= 8 && c <= 14) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_quiet cyc=%0d got=%b exp=0", c, rsp_valid); end
      end
      if (c == 7) begin
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL hold_idle_busy got=%b exp=0", idle); end
      end
      if (c == 8 || c == 9) begin
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hold_idle cyc=%0d got=%b exp=1", c, idle); end
      end
      if (c == 15) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_res !== P - 16'd3) begin
          errors++; $display("FAIL hold_resume_rsp got v=%b id=%0d res=%0d exp 1/2/%0d", rsp_valid, rsp_id, rsp_res, P - 16'd3); end
      end
      step();
    end
    drain();
  endtask

  task automatic test_tag;
    set_req(0, 2, 1, 1, 0);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step(); step(); step(); step();
    checks++; if ({rsp_valid, rsp_rn, rsp_res} !== {1'b1, 4'd0, 16'd2}) begin
      errors++; $display("FAIL tag_rn0_rsp got v=%b rn=%0d res=%0d exp 1/0/2", rsp_valid, rsp_rn, rsp_res); end
    step();
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_rn0_err got=%b exp=0", tag_err); end
    set_req(1, 1, 4, 0, 5);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step(); step(); step(); step();
    rn_flip = 4'b0001;
    #1;
    checks++; if ({rsp_valid, rsp_rn, rsp_res} !== {1'b1, 4'd5, 16'd8}) begin
      errors++; $display("FAIL tag_dbl_rsp got v=%b rn=%0d res=%0d exp 1/5/8", rsp_valid, rsp_rn, rsp_res); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_err_early got=%b exp=0", tag_err); end
    step();
    rn_flip = '0;
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tag_err_set got=%b exp=1", tag_err); end
    repeat (5) step();
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tag_err_sticky got=%b exp=1", tag_err); end
    rst_n = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_err_reset got=%b exp=0", tag_err); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; rn_flip = '0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_rn = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_to_back();
    test_hold();
    test_tag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
